// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Read misses refill a full line one word at a time; every store is
// written through to memory and updates the line only if it hits.
module dcache_controller #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [65:0] cpu_bus_in,
    output logic [32:0] cpu_bus_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

    state_t state, state_nxt;

    logic              req_en;
    logic              req_we;
    logic [29:0]       req_waddr;
    logic [31:0]       req_wdata;
    logic              addr_lsb_unused;
    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [31:0]       data [LINES][WORDS];

    logic [29:0]       lat_waddr;
    logic [31:0]       lat_wdata;
    logic [OFF_W-1:0]  cnt;
    logic [OFF_W-1:0]  lat_off;
    logic [IDX_W-1:0]  lat_idx;
    logic [TAG_W-1:0]  lat_tag;

    logic              hit;
    logic              lat_hit;
    logic              last_word;

    assign req_en          = cpu_bus_in[65];
    assign req_we          = cpu_bus_in[64];
    assign req_waddr       = cpu_bus_in[63:34];
    assign addr_lsb_unused = ^cpu_bus_in[33:32];
    assign req_wdata       = cpu_bus_in[31:0];

    assign req_off = req_waddr[OFF_W-1:0];
    assign req_idx = req_waddr[OFF_W +: IDX_W];
    assign req_tag = req_waddr[29 -: TAG_W];

    assign lat_off = lat_waddr[OFF_W-1:0];
    assign lat_idx = lat_waddr[OFF_W +: IDX_W];
    assign lat_tag = lat_waddr[29 -: TAG_W];

    assign hit       = req_en & valid[req_idx] & (tags[req_idx] == req_tag);
    assign lat_hit   = valid[lat_idx] & (tags[lat_idx] == lat_tag);
    assign last_word = (cnt == OFF_W'(WORDS - 1));

    // State register, valid bits and the latched request (async active-low reset)
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            valid     <= '0;
            cnt       <= '0;
            lat_waddr <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    // Latching unconditionally in IDLE is harmless: the copy is
                    // only consumed after a transition out of IDLE.
                    lat_waddr <= req_waddr;
                    lat_wdata <= req_wdata;
                    cnt       <= '0;
                end
                REFILL: begin
                    if (mem_ack) begin
                        cnt <= cnt + OFF_W'(1);
                        if (last_word) begin
                            valid[lat_idx] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays: refill words, tag on the final refill word, store-hit update
    always_ff @(posedge Clk) begin
        if (state == REFILL && mem_ack) begin
            data[lat_idx][cnt] <= mem_rdata;
            if (last_word) begin
                tags[lat_idx] <= lat_tag;
            end
        end
        if (state == WRITE && mem_ack && lat_hit) begin
            data[lat_idx][lat_off] <= lat_wdata;
        end
    end

    // Next-state logic and all outputs; memory port driven only from registers
    always_comb begin
        state_nxt   = state;
        cpu_bus_out = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state)
            IDLE: begin
                if (req_en) begin
                    if (req_we) begin
                        cpu_bus_out[32] = 1'b1;
                        state_nxt       = WRITE;
                    end else if (hit) begin
                        cpu_bus_out[31:0] = data[req_idx][req_off];
                    end else begin
                        cpu_bus_out[32] = 1'b1;
                        state_nxt       = REFILL;
                    end
                end
            end
            REFILL: begin
                cpu_bus_out[32] = 1'b1;
                mem_req         = 1'b1;
                mem_addr        = {lat_waddr[29:OFF_W], cnt, 2'b00};
                if (mem_ack && last_word) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                cpu_bus_out[32] = 1'b1;
                mem_req         = 1'b1;
                mem_we          = 1'b1;
                mem_addr        = {lat_waddr, 2'b00};
                mem_wdata       = lat_wdata;
                if (mem_ack) begin
                    state_nxt = WDONE;
                end
            end
            WDONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
